// File: rtl/nic_endpoint.sv
// Network interface between one PE and a mesh router PE port: one-flit eject and inject buffers behind a 2-bit register map.
// Optional overflow counter for dropped output-buffer writes is enabled with `define NIC_OVF_CNT_EN.
module nic_endpoint #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_polarity,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di
);

   localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   logic [DATA_WIDTH-1:0] r_inBuf;
   logic                  r_inFull;
   logic [DATA_WIDTH-1:0] r_outBuf;
   logic                  r_outFull;
   logic [DATA_WIDTH-1:0] r_dOut;

   logic                  w_peRead;
   logic                  w_peWrite;
   logic                  w_inAccept;
   logic                  w_inDrain;
   logic                  w_outLoad;
   logic                  w_send;
   logic [DATA_WIDTH-1:0] w_inStatus;
   logic [DATA_WIDTH-1:0] w_outStatus;

   assign w_peRead   = nicEn & ~nicWrEn;
   assign w_peWrite  = nicEn & nicWrEn;
   assign w_inAccept = net_si & ~r_inFull;
   assign w_inDrain  = w_peRead & (addr == ADDR_IN_BUF) & r_inFull;
   assign w_outLoad  = w_peWrite & (addr == ADDR_OUT_BUF) & ~r_outFull;
   // A flit may only leave on the polarity phase matching its vc bit.
   assign w_send     = r_outFull & net_ro & (r_outBuf[DATA_WIDTH-1] == net_polarity);

   assign net_ri = ~r_inFull;
   assign net_so = w_send;
   assign net_do = r_outBuf;
   assign d_out  = r_dOut;

`ifdef NIC_OVF_CNT_EN
   logic [7:0] r_ovfCnt;
   logic       w_outDrop;

   assign w_outDrop = w_peWrite & (addr == ADDR_OUT_BUF) & r_outFull;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovfCnt <= '0;
      end else if (w_outDrop && (r_ovfCnt != 8'hFF)) begin
         r_ovfCnt <= r_ovfCnt + 8'd1;
      end
   end
`endif

   always_comb begin
      w_inStatus     = '0;
      w_inStatus[0]  = r_inFull;
      w_outStatus    = '0;
      w_outStatus[0] = r_outFull;
`ifdef NIC_OVF_CNT_EN
      w_outStatus[15:8] = r_ovfCnt;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inBuf  <= '0;
         r_inFull <= 1'b0;
      end else if (w_inAccept) begin
         r_inBuf  <= net_di;
         r_inFull <= 1'b1;
      end else if (w_inDrain) begin
         r_inFull <= 1'b0;
      end
   end

   // Load and send never coincide: a load needs the buffer empty, a send needs it full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outBuf  <= '0;
         r_outFull <= 1'b0;
      end else if (w_send) begin
         r_outFull <= 1'b0;
      end else if (w_outLoad) begin
         r_outBuf  <= d_in;
         r_outFull <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dOut <= '0;
      end else if (w_peRead) begin
         case (addr)
            ADDR_IN_BUF:   r_dOut <= r_inBuf;
            ADDR_IN_STAT:  r_dOut <= w_inStatus;
            ADDR_OUT_BUF:  r_dOut <= r_outBuf;
            ADDR_OUT_STAT: r_dOut <= w_outStatus;
            default:       r_dOut <= r_dOut;
         endcase
      end
   end

endmodule
